// File: rtl/page_pkg.sv
// page_pkg: shared state encoding, koffset values and default sizing for the page sequencer
package page_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ALIGN    = 3'd1,
    PAGE_TX  = 3'd2,
    PAGE_RX  = 3'd3,
    RSP_FHS  = 3'd4,
    RSP_WAIT = 3'd5
  } page_state_e;
  localparam logic [4:0] KOFFSET_A = 5'd24;
  localparam logic [4:0] KOFFSET_B = 5'd8;
  localparam int NPAGE_DEF = 128;
  localparam int TRAIN_SLOTS_DEF = 16;
  localparam int RSP_RETRY_DEF = 4;
endpackage

// File: rtl/page_train_cnt.sv
// page_train_cnt: pair/rep counters, A/B train toggle and ID index for the page hop kernel
module page_train_cnt
  import page_pkg::*;
#(
  parameter int NPAGE = NPAGE_DEF,
  parameter int TRAIN_SLOTS = TRAIN_SLOTS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc_pair,
  input  logic       half,
  output logic       train_sel,
  output logic [4:0] koffset,
  output logic [3:0] x_idx
);
  localparam logic [2:0] PAIR_LAST = 3'(TRAIN_SLOTS / 2 - 1);
  localparam logic [7:0] REP_LAST = 8'(NPAGE - 1);
  logic [2:0] pair_q, pair_d;
  logic [7:0] rep_q, rep_d;
  logic       train_q, wrap, flip;
  logic [3:0] x_idx_q;
  // next pair/rep values: a full train of pairs bumps rep, NPAGE reps flip the train
  always_comb begin
    wrap = pair_q == PAIR_LAST;
    flip = wrap && rep_q == REP_LAST;
    pair_d = wrap ? 3'd0 : pair_q + 3'd1;
    rep_d = !wrap ? rep_q : flip ? 8'd0 : (rep_q == 8'hff ? rep_q : rep_q + 8'd1);
  end
  // counters advance on inc_pair; the odd ID index is selected at half-slot
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pair_q  <= '0;
      rep_q   <= '0;
      train_q <= 1'b0;
      x_idx_q <= '0;
    end else if (inc_pair) begin
      pair_q  <= pair_d;
      rep_q   <= rep_d;
      train_q <= train_q ^ flip;
      x_idx_q <= {pair_d, 1'b0};
    end else if (half) begin
      x_idx_q <= {pair_q, 1'b1};
    end
  end
  assign train_sel = train_q;
  assign koffset = train_q ? KOFFSET_B : KOFFSET_A;
  assign x_idx = x_idx_q;
endmodule

// File: rtl/page_train_ctrl.sv
// page_train_ctrl: master page-mode sequencer driving ID trains, RX windows and the FHS handshake
module page_train_ctrl
  import page_pkg::*;
#(
  parameter int NPAGE = NPAGE_DEF,
  parameter int TRAIN_SLOTS = TRAIN_SLOTS_DEF,
  parameter int RSP_RETRY = RSP_RETRY_DEF
) (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        page_start,
  input  logic        page_abort,
  input  logic [15:0] regi_page_timeout,
  input  logic [27:0] CLKE_master,
  input  logic        m_tslot_p,
  input  logic        m_half_tslot_p,
  input  logic        id_rx_p,
  output logic [2:0]  state,
  output logic        train_sel,
  output logic [4:0]  koffset,
  output logic [3:0]  x_idx,
  output logic        tx_id_p,
  output logic        fhs_tx_p,
  output logic        rx_win,
  output logic        page_done_p,
  output logic        page_timeout_p,
  output logic        page_fail_p
);
  localparam logic [2:0] RETRY_MAX = 3'(RSP_RETRY);
  page_state_e state_q;
  logic [15:0] tmo_q;
  logic [2:0]  retry_q;
  logic        tx_id_q, fhs_q, rx_win_q, done_q, tmo_p_q, fail_q;
  logic        paging, id_hit, tmo_hit, clear, inc_pair, half;
  logic        unused_clke;
  assign unused_clke = ^{CLKE_master[27:2], CLKE_master[0]};
  assign paging = state_q inside {ALIGN, PAGE_TX, PAGE_RX};
  assign id_hit = id_rx_p && rx_win_q;
  assign tmo_hit = paging && m_tslot_p && regi_page_timeout != 16'd0 &&
                   tmo_q + 16'd1 == regi_page_timeout;
  assign clear = state_q == IDLE && page_start && !page_abort;
  assign inc_pair = state_q == PAGE_RX && m_tslot_p && !page_abort && !id_hit && !tmo_hit;
  assign half = state_q == PAGE_TX && m_half_tslot_p && !m_tslot_p && !page_abort;
  page_train_cnt #(.NPAGE(NPAGE), .TRAIN_SLOTS(TRAIN_SLOTS)) u_cnt (
    .clk(clk_6M),
    .rst(rst),
    .clear(clear),
    .inc_pair(inc_pair),
    .half(half),
    .train_sel(train_sel),
    .koffset(koffset),
    .x_idx(x_idx)
  );
  // page FSM: abort beats a received ID, which beats timeout, which beats slot events
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      retry_q  <= '0;
      rx_win_q <= 1'b0;
      {tx_id_q, fhs_q, done_q, tmo_p_q, fail_q} <= '0;
    end else begin
      {tx_id_q, fhs_q, done_q, tmo_p_q, fail_q} <= '0;
      if (page_abort) begin
        state_q  <= IDLE;
        rx_win_q <= 1'b0;
      end else if (id_hit) begin
        rx_win_q <= 1'b0;
        done_q   <= state_q == RSP_WAIT;
        state_q  <= state_q == RSP_WAIT ? IDLE : RSP_FHS;
      end else if (tmo_hit) begin
        tmo_p_q <= 1'b1;
        state_q <= IDLE;
      end else begin
        if (paging && m_tslot_p) tmo_q <= tmo_q + 16'd1;
        case (state_q)
          IDLE: if (page_start) begin
            state_q <= ALIGN;
            tmo_q   <= '0;
            retry_q <= '0;
          end
          ALIGN: if (m_tslot_p && CLKE_master[1]) begin
            state_q <= PAGE_TX;
            tx_id_q <= 1'b1;
          end
          PAGE_TX: if (m_tslot_p) begin
            state_q  <= PAGE_RX;
            rx_win_q <= 1'b1;
          end else if (m_half_tslot_p) begin
            tx_id_q <= 1'b1;
          end
          PAGE_RX: if (m_tslot_p) begin
            state_q  <= PAGE_TX;
            rx_win_q <= 1'b0;
            tx_id_q  <= 1'b1;
          end
          RSP_FHS: if (m_tslot_p) begin
            state_q <= RSP_WAIT;
            fhs_q   <= 1'b1;
            retry_q <= retry_q + 3'd1;
          end
          RSP_WAIT: if (m_tslot_p) begin
            rx_win_q <= !rx_win_q;
            if (rx_win_q) begin
              fail_q  <= retry_q >= RETRY_MAX;
              state_q <= retry_q < RETRY_MAX ? RSP_FHS : IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign state = state_q;
  assign tx_id_p = tx_id_q;
  assign fhs_tx_p = fhs_q;
  assign rx_win = rx_win_q;
  assign page_done_p = done_q;
  assign page_timeout_p = tmo_p_q;
  assign page_fail_p = fail_q;
endmodule

// File: tb/tb_page_train_ctrl.sv
// tb_page_train_ctrl: directed page scenarios checked against an event-level model every cycle
module tb_page_train_ctrl;
  localparam int NP = 2;
  localparam int TS = 16;
  localparam int RR = 4;
  logic        clk_6M = 0, rst = 1, page_start = 0, page_abort = 0;
  logic [15:0] regi_page_timeout = 0;
  logic [27:0] CLKE_master = 0;
  logic        m_tslot_p = 0, m_half_tslot_p = 0, id_rx_p = 0;
  logic [2:0]  state;
  logic        train_sel, tx_id_p, fhs_tx_p, rx_win, page_done_p, page_timeout_p, page_fail_p;
  logic [4:0]  koffset;
  logic [3:0]  x_idx;
  int tests = 0, fails = 0;
  int n_tx = 0, n_fhs = 0, n_done = 0, n_tmo = 0, n_fail = 0;
  int b0, b1, b2;

  page_train_ctrl #(.NPAGE(NP), .TRAIN_SLOTS(TS), .RSP_RETRY(RR)) dut (
    .clk_6M(clk_6M), .rst(rst), .page_start(page_start), .page_abort(page_abort),
    .regi_page_timeout(regi_page_timeout), .CLKE_master(CLKE_master),
    .m_tslot_p(m_tslot_p), .m_half_tslot_p(m_half_tslot_p), .id_rx_p(id_rx_p),
    .state(state), .train_sel(train_sel), .koffset(koffset), .x_idx(x_idx),
    .tx_id_p(tx_id_p), .fhs_tx_p(fhs_tx_p), .rx_win(rx_win), .page_done_p(page_done_p),
    .page_timeout_p(page_timeout_p), .page_fail_p(page_fail_p)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  // Model: phase per spec state number, total pairs sent since start, slot/FHS counts.
  int  e_st, pairs, slots, fhs_n;
  bit  mv, odd, e_win, e_tx, e_fhs, e_done, e_tmo, e_fail, paging, hit, tmo;
  always @(posedge clk_6M) begin
    {e_tx, e_fhs, e_done, e_tmo, e_fail} = '0;
    paging = e_st >= 1 && e_st <= 3;
    hit = id_rx_p && e_win;
    tmo = paging && m_tslot_p && regi_page_timeout != 0 && slots + 1 == int'(regi_page_timeout);
    if (rst) begin
      mv = 1; e_st = 0; pairs = 0; odd = 0; e_win = 0; slots = 0; fhs_n = 0;
    end else if (page_abort) begin
      e_st = 0; e_win = 0;
    end else if (hit) begin
      e_win = 0; e_done = e_st == 5; e_st = e_st == 5 ? 0 : 4;
    end else if (tmo) begin
      e_tmo = 1; e_st = 0;
    end else begin
      if (paging && m_tslot_p) slots++;
      if (e_st == 0 && page_start) begin
        e_st = 1; slots = 0; pairs = 0; odd = 0; fhs_n = 0;
      end else if (m_tslot_p) begin
        if (e_st == 1 && CLKE_master[1]) begin e_st = 2; e_tx = 1; end
        else if (e_st == 2) begin e_st = 3; e_win = 1; end
        else if (e_st == 3) begin e_st = 2; e_win = 0; e_tx = 1; pairs++; odd = 0; end
        else if (e_st == 4) begin e_st = 5; e_fhs = 1; fhs_n++; end
        else if (e_st == 5) begin
          if (!e_win) e_win = 1;
          else begin
            e_win = 0;
            if (fhs_n < RR) e_st = 4;
            else begin e_fail = 1; e_st = 0; end
          end
        end
      end else if (m_half_tslot_p && e_st == 2) begin
        e_tx = 1; odd = 1;
      end
    end
  end

  // compare DUT against the model mid-cycle, and tally DUT pulses for directed checks
  always @(negedge clk_6M) begin
    n_tx += int'(tx_id_p); n_fhs += int'(fhs_tx_p); n_done += int'(page_done_p);
    n_tmo += int'(page_timeout_p); n_fail += int'(page_fail_p);
    if (mv) begin
      chk("state", 32'(state), e_st);
      chk("train_sel", 32'(train_sel), (pairs / (NP * TS / 2)) % 2);
      chk("koffset", 32'(koffset), ((pairs / (NP * TS / 2)) % 2) ? 8 : 24);
      chk("x_idx", 32'(x_idx), 2 * (pairs % (TS / 2)) + int'(odd));
      chk("tx_id_p", 32'(tx_id_p), 32'(e_tx));
      chk("fhs_tx_p", 32'(fhs_tx_p), 32'(e_fhs));
      chk("rx_win", 32'(rx_win), 32'(e_win));
      chk("page_done_p", 32'(page_done_p), 32'(e_done));
      chk("page_timeout_p", 32'(page_timeout_p), 32'(e_tmo));
      chk("page_fail_p", 32'(page_fail_p), 32'(e_fail));
    end
  end

  task automatic step(input bit h, input bit t, input bit id, input bit c1);
    m_half_tslot_p = h; m_tslot_p = t; id_rx_p = id; CLKE_master = {26'd0, c1, 1'b0};
    @(posedge clk_6M); #1;
    m_half_tslot_p = 0; m_tslot_p = 0; id_rx_p = 0; page_start = 0; page_abort = 0;
  endtask

  // one 6-cycle slot: half-slot pulse mid-way, optional ID hit, slot-end pulse last
  task automatic slot(input bit next_tx, input bit id);
    for (int i = 0; i < 6; i++) step(i == 2, i == 5, id && i == 3, next_tx);
  endtask

  task automatic start();
    page_start = 1;
    step(0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) step(0, 0, 0, 0);
    rst = 0;
    step(0, 0, 0, 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_koffset", 32'(koffset), 24);
    chk("rst_x_idx", 32'(x_idx), 0);
    chk("rst_rx_win", 32'(rx_win), 0);
    // basic TX pattern and abort in PAGE_RX
    b0 = n_tx;
    start();
    chk("start_align", 32'(state), 1);
    slot(1, 0);
    chk("align_tx", 32'(tx_id_p), 1);
    chk("align_state", 32'(state), 2);
    chk("align_x", 32'(x_idx), 0);
    slot(0, 0);
    chk("tx1_x", 32'(x_idx), 1);
    chk("tx1_win", 32'(rx_win), 1);
    chk("tx1_cnt", n_tx - b0, 2);
    slot(1, 0);
    chk("rx1_x", 32'(x_idx), 2);
    chk("rx1_tx", 32'(tx_id_p), 1);
    slot(0, 0);
    chk("tx2_x", 32'(x_idx), 3);
    page_abort = 1;
    step(0, 0, 0, 0);
    chk("abort_state", 32'(state), 0);
    chk("abort_win", 32'(rx_win), 0);
    chk("abort_tx", 32'(tx_id_p), 0);
    // train switch over 64 pairs with NPAGE = 2
    start();
    b0 = n_tx;
    slot(1, 0);
    for (int k = 0; k < 32; k++) begin
      slot(0, 0);
      if (k == 15) chk("pre_switch", 32'(train_sel), 0);
      if (k == 31) chk("pre_back", 32'(train_sel), 1);
      slot(1, 0);
      if (k == 15) begin
        chk("switch_cnt", n_tx - b0, 32);
        chk("switch_sel", 32'(train_sel), 1);
        chk("switch_koff", 32'(koffset), 8);
      end
      if (k == 31) chk("back_koff", 32'(koffset), 24);
    end
    // full handshake
    slot(0, 0);
    slot(1, 1);
    chk("hs_fhs", 32'(fhs_tx_p), 1);
    chk("hs_wait", 32'(state), 5);
    slot(0, 0);
    chk("hs_win", 32'(rx_win), 1);
    b0 = n_done;
    slot(1, 1);
    chk("hs_done", n_done - b0, 1);
    chk("hs_idle", 32'(state), 0);
    // response failure
    b0 = n_fhs; b1 = n_fail; b2 = n_done;
    start();
    slot(1, 0); slot(0, 0); slot(1, 1);
    for (int k = 0; k < 13; k++) slot(k % 2 == 0 ? 1'b0 : 1'b1, 0);
    chk("fail_fhs", n_fhs - b0, 4);
    chk("fail_p", n_fail - b1, 1);
    chk("fail_nodone", n_done - b2, 0);
    // timeout at 10 slots
    regi_page_timeout = 10;
    b1 = n_tmo;
    start();
    for (int i = 0; i < 10; i++) slot(i % 2 == 0, 0);
    chk("tmo_p", 32'(page_timeout_p), 1);
    chk("tmo_idle", 32'(state), 0);
    b0 = n_tx;
    slot(1, 0); slot(0, 0);
    chk("tmo_notx", n_tx - b0, 0);
    chk("tmo_cnt", n_tmo - b1, 1);
    // timeout disabled for 1000 slots
    regi_page_timeout = 0;
    b1 = n_tmo;
    start();
    for (int i = 0; i < 1000; i++) slot(i % 2 == 0, 0);
    chk("notmo_cnt", n_tmo - b1, 0);
    chk("notmo_state", 32'(state), 3);
    // reset during RSP_WAIT
    start();
    slot(1, 0); slot(0, 0); slot(1, 1);
    chk("pre_rst", 32'(state), 5);
    rst = 1;
    step(0, 0, 0, 0);
    rst = 0;
    chk("rst2_state", 32'(state), 0);
    chk("rst2_x", 32'(x_idx), 0);
    chk("rst2_koff", 32'(koffset), 24);
    chk("rst2_win", 32'(rx_win), 0);
    // start together with abort stays idle
    page_start = 1; page_abort = 1;
    step(0, 0, 0, 0);
    chk("start_abort", 32'(state), 0);
    step(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/page_train_ctrl.md
Name: page_train_ctrl

Overview:
- Master-side page-mode sequencer, directly downstream of the Bluetooth clock/timing block.
- Consumes CLKE_master, m_tslot_p and m_half_tslot_p, and drives the page scheme:
  - ID TX pulses at slot start and at half-slot;
  - RX listen windows;
  - A/B train selection with koffset;
  - master page-response FHS handshake.
- Feeds the hop-selection kernel (train_sel, koffset, x_idx) and the TX/RX packet controllers.

Parameters:
- NPAGE, 128, train repetitions (16-slot trains) before A/B toggle; legal range 1..255.
- TRAIN_SLOTS, 16, slots per train; must be even.
- RSP_RETRY, 4, FHS transmissions attempted before page_fail_p.

Ports:
- clk_6M  in  1  6 MHz system clock.
- rst  in  1  reset.
- page_start  in  1  one-cycle request to begin paging.
- page_abort  in  1  one-cycle cancel.
- regi_page_timeout  in  16  page timeout in slots; 0 = disabled.
- CLKE_master  in  28  estimated slave clock (only bit 1 used).
- m_tslot_p  in  1  slot-end pulse.
- m_half_tslot_p  in  1  mid-slot pulse.
- id_rx_p  in  1  ID correlator hit.
- state  out  3  current FSM state.
- train_sel  out  1  0 = train A, 1 = train B.
- koffset  out  5  24 (A) or 8 (B).
- x_idx  out  4  ID index within train, 0..15.
- tx_id_p  out  1  start one ID transmission.
- fhs_tx_p  out  1  start FHS transmission.
- rx_win  out  1  receiver enable.
- page_done_p  out  1  connection established.
- page_timeout_p  out  1  timeout expired.
- page_fail_p  out  1  response phase failed.

Behaviour:
- One clock, clk_6M. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: state = IDLE, train_sel = 0, koffset = 24, x_idx = 0, all pulses 0, rx_win = 0.
- Slot convention: m_tslot_p ends a slot. The next slot is a master TX slot iff CLKE_master[1] == 1 at that pulse.
- FSM states and transitions:
  - IDLE (0): page_start -> ALIGN. Clears the pair, rep and timeout counters, and sets train_sel = 0.
  - ALIGN (1): on m_tslot_p with CLKE_master[1] == 1 -> PAGE_TX. tx_id_p is asserted the cycle after that pulse.
  - PAGE_TX (2):
    - m_half_tslot_p -> tx_id_p, x_idx = 2*pair + 1.
    - On entry, x_idx = 2*pair.
    - m_tslot_p -> PAGE_RX.
  - PAGE_RX (3):
    - rx_win = 1 for the whole slot.
    - id_rx_p -> RSP_FHS.
    - Otherwise m_tslot_p -> PAGE_TX: pair increments; tx_id_p fires the cycle after the pulse.
    - When pair wraps at TRAIN_SLOTS/2 - 1 -> 0, rep increments.
    - When rep reaches NPAGE: rep = 0, train_sel toggles, koffset follows.
  - RSP_FHS (4): rx_win = 0. At the next m_tslot_p (TX slot start), fhs_tx_p fires -> RSP_WAIT. The retry counter increments.
  - RSP_WAIT (5):
    - The FHS slot ends at m_tslot_p, then rx_win = 1 for the following RX slot.
    - id_rx_p inside that window -> page_done_p, then IDLE.
    - Window end without ID: if retry < RSP_RETRY -> RSP_FHS; else page_fail_p -> IDLE.
- Timeout:
  - Counts m_tslot_p in ALIGN/PAGE_TX/PAGE_RX.
  - On count == regi_page_timeout (nonzero): page_timeout_p, then IDLE.
  - The timeout counter freezes in the response states.
- Priorities:
  - rst > page_abort > id_rx_p > timeout > slot/half-slot events.
  - page_abort in any state -> IDLE next cycle, rx_win = 0, no status pulse.
  - page_start while not IDLE is ignored.
  - page_start together with page_abort -> stays IDLE.
- id_rx_p with rx_win == 0 is ignored.
- m_half_tslot_p and m_tslot_p are never coincident; if they are, the slot event wins.
- Counter widths: pair 3 bits, rep 8 bits (saturates), timeout 16 bits, retry 3 bits.

Decomposition:
- Shared package page_pkg holds:
  - FSM state encoding constants (IDLE..RSP_WAIT);
  - KOFFSET_A = 24, KOFFSET_B = 8;
  - default NPAGE and TRAIN_SLOTS.
- One natural sub-module: page_train_cnt. It contains the pair/rep counters, the A/B toggle, koffset and x_idx. The FSM drives it with inc_pair and clear strobes.

Test Plan:
- Basic TX pattern: page_start, CLKE[1] = 1 at the next m_tslot_p -> tx_id_p one cycle later and at m_half_tslot_p with x_idx 0,1; the following slot has rx_win = 1; the next TX slot gives x_idx 2,3.
- Train switch: NPAGE = 2, no id_rx_p for 32 slots -> 32 slots × 1 ID = 32 tx_id_p (two per TX slot); train_sel 0 -> 1, koffset 24 -> 8 at the end of slot 32; it toggles back after slot 64.
- Full handshake: id_rx_p in PAGE_RX -> fhs_tx_p at the next slot boundary, then id_rx_p in the following RX slot -> page_done_p; state = IDLE.
- Response failure: RSP_RETRY = 4 with no slave ID -> exactly 4 fhs_tx_p, then page_fail_p; no page_done_p.
- Timeout: regi_page_timeout = 10 -> page_timeout_p at the 10th m_tslot_p after page_start; no tx_id_p afterwards. With regi_page_timeout = 0, no timeout occurs after 1000 slots.
- Abort and reset mid-operation: page_abort in PAGE_RX -> next cycle IDLE with rx_win = 0 and no pulses. rst asserted during RSP_WAIT -> all outputs return to their reset values.
